// File: rtl/hl_load_arbiter_pkg.sv
// Shared types and constants for the high/low load arbiter.
package hl_pkg;

   // Width of the completed-word counter.
   localparam int CNT_W = 8;

   // Word-assembly phases: wait for a requester, take the high beat,
   // take the low beat, then flag the finished word for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Completed-word counter step; wraps naturally from all-ones to zero.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return c + 1'b1;
   endfunction

endpackage

// File: rtl/hl_load_arbiter_if.sv
// Requester-side handshake bundle: two requesters share one set of
// valid/ready bits, each with its own half-word data bus.
interface hl_load_arbiter_if #(
   parameter int N = 16
);

   logic [1:0]     req_valid;
   logic [N/2-1:0] req_byte0;
   logic [N/2-1:0] req_byte1;
   logic [1:0]     req_ready;

   // Requesters drive valid/data and observe ready.
   modport master (
      output req_valid, req_byte0, req_byte1,
      input  req_ready
   );

   // The arbiter observes valid/data and drives ready.
   modport slave (
      input  req_valid, req_byte0, req_byte1,
      output req_ready
   );

endinterface

// File: rtl/hl_load_arbiter_rr_arb2.sv
// Two-way round-robin chooser: a lone request wins outright, a tie goes
// to the requester that was not served last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // One-hot grant from the request pair and the last-served index.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path can leave it unassigned and infer a latch.
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/hl_load_arbiter.sv
// Collects a two-beat word (high half, then low half) from one of two
// requesters and steers it into an external split high/low register.
module hl_load_arbiter
   import hl_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                clk,
   input  logic                reset,
   hl_load_arbiter_if.slave    req,
   input  logic                abort,
   output logic [N/2-1:0]      inh,
   output logic [N/2-1:0]      inl,
   output logic                loadh,
   output logic                loadl,
   output logic                reg_clear,
   output logic                word_valid,
   output logic                word_src,
   output logic [CNT_W-1:0]    word_count
);

   localparam int H = N / 2;

   if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("hl_load_arbiter: N must be even and at least 4");
   end

   state_t         state_q, state_d;
   logic           grant_q, grant_d;   // index of the requester owning the word
   logic           last_q,  last_d;    // requester served by the last completed word
   logic [CNT_W-1:0] count_d;
   logic [1:0]     gnt;
   logic [1:0]     ready;
   logic [H-1:0]   beat;

   rr_arb2 u_rr (
      .req  (req.req_valid),
      .last (last_q),
      .gnt  (gnt)
   );

   // Data beat offered by the currently granted requester.
   assign beat          = grant_q ? req.req_byte1 : req.req_byte0;
   assign req.req_ready = ready;
   assign word_src      = grant_q;

   // State, grant, last-served pointer and word counter registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;   // last served = 1, so a tie favours requester 0
         word_count <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         word_count <= count_d;
      end
   end

   // Next-state and strobe generation; abort outranks any transfer and
   // reset forces the outputs to their quiet values combinationally.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      count_d    = word_count;
      ready      = 2'b00;
      loadh      = 1'b0;
      loadl      = 1'b0;
      inh        = '0;
      inl        = '0;
      reg_clear  = 1'b0;
      word_valid = 1'b0;

      if (abort) begin
         reg_clear = 1'b1;
         state_d   = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt != 2'b00) begin
                  grant_d = gnt[1];
                  state_d = HIGH;
               end
            end
            HIGH: begin
               ready[grant_q] = 1'b1;
               if (req.req_valid[grant_q]) begin
                  loadh   = 1'b1;
                  inh     = beat;
                  state_d = LOW;
               end
            end
            LOW: begin
               ready[grant_q] = 1'b1;
               if (req.req_valid[grant_q]) begin
                  loadl   = 1'b1;
                  inl     = beat;
                  state_d = DONE;
               end
            end
            DONE: begin
               word_valid = 1'b1;
               count_d    = cnt_inc(word_count);
               last_d     = grant_q;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (reset) begin
         ready      = 2'b00;
         loadh      = 1'b0;
         loadl      = 1'b0;
         inh        = '0;
         inl        = '0;
         word_valid = 1'b0;
         reg_clear  = 1'b1;
      end
   end

endmodule

// File: tb/tb_hl_load_arbiter.sv
// Directed bench for hl_load_arbiter with the split high/low register
// modelled alongside and a queue of expected words.
module tb_hl_load_arbiter;
   import hl_pkg::*;

   localparam int N = 16;
   localparam int H = N / 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             abort;
   logic [H-1:0]     inh, inl;
   logic             loadh, loadl, reg_clear, word_valid, word_src;
   logic [CNT_W-1:0] word_count;

   hl_load_arbiter_if #(.N(N)) rif ();

   hl_load_arbiter #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (rif.slave),
      .abort      (abort),
      .inh        (inh),
      .inl        (inl),
      .loadh      (loadh),
      .loadl      (loadl),
      .reg_clear  (reg_clear),
      .word_valid (word_valid),
      .word_src   (word_src),
      .word_count (word_count)
   );

   // Split high/low register driven by the arbiter strobes.
   logic [N-1:0] reg_q;
   always @(posedge clk) begin
      if (reg_clear) reg_q <= '0;
      else begin
         if (loadh) reg_q[N-1:H] <= inh;
         if (loadl) reg_q[H-1:0] <= inl;
      end
   end

   typedef struct packed {
      logic         src;
      logic [N-1:0] data;
   } word_t;

   word_t exp_q[$];
   int n_checks  = 0;
   int n_errors  = 0;
   int exp_count = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [H-1:0] hi_b(input int g, input int k);
      return H'(32'hA0 + 16 * g + k);
   endfunction

   function automatic logic [H-1:0] lo_b(input int g, input int k);
      return H'(32'h05 + 16 * g + 3 * k);
   endfunction

   task automatic push_exp(input logic src, input logic [N-1:0] data);
      word_t w;
      w.src  = src;
      w.data = data;
      exp_q.push_back(w);
   endtask

   // Compare the flagged word against the oldest expectation.
   task automatic check_word();
      word_t w;
      chk("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         chk("word_src", word_src, w.src);
         chk("word_data", reg_q, w.data);
         exp_count++;
      end
   endtask

   // Each requester sends its words back to back, keeping valid high until
   // its quota is done; words are checked as word_valid appears.
   task automatic rr_run(input int nw0, input int nw1, input int budget);
      int need[2];
      int wc[2];
      int bidx[2];
      int got;
      int total;
      int c;
      need[0] = nw0; need[1] = nw1;
      wc[0] = 0; wc[1] = 0; bidx[0] = 0; bidx[1] = 0;
      got = 0; c = 0; total = nw0 + nw1;
      while (got < total && c < budget) begin
         for (int g = 0; g < 2; g++) rif.req_valid[g] = (wc[g] < need[g]);
         rif.req_byte0 = (bidx[0] == 0) ? hi_b(0, wc[0]) : lo_b(0, wc[0]);
         rif.req_byte1 = (bidx[1] == 0) ? hi_b(1, wc[1]) : lo_b(1, wc[1]);
         settle();
         chk("no_dual_load", loadh & loadl, 0);
         if (word_valid) begin
            check_word();
            got++;
         end
         for (int g = 0; g < 2; g++) begin
            if (rif.req_ready[g] && rif.req_valid[g]) begin
               if (bidx[g] == 0) begin
                  chk("rr_loadh", loadh, 1);
                  chk("rr_inh", inh, hi_b(g, wc[g]));
                  bidx[g] = 1;
               end else begin
                  chk("rr_loadl", loadl, 1);
                  chk("rr_inl", inl, lo_b(g, wc[g]));
                  bidx[g] = 0;
                  wc[g]++;
               end
            end
         end
         cyc();
         c++;
      end
      rif.req_valid = 2'b00;
      chk("rr_words_done", got, total);
   endtask

   initial begin
      int nwrap;
      reset = 1'b1;
      abort = 1'b0;
      rif.req_valid = 2'b00;
      rif.req_byte0 = '0;
      rif.req_byte1 = '0;

      // Reset values, with both requesters shouting during reset.
      rif.req_valid = 2'b11;
      cyc(); cyc(); settle();
      chk("rst_word_valid", word_valid, 0);
      chk("rst_loadh", loadh, 0);
      chk("rst_loadl", loadl, 0);
      chk("rst_ready", rif.req_ready, 2'b00);
      chk("rst_reg_clear", reg_clear, 1);
      chk("rst_word_count", word_count, 0);
      chk("rst_word_src", word_src, 0);
      rif.req_valid = 2'b00;
      reset = 1'b0;
      cyc();

      // Requester 0 sends 0xAB then 0xCD.
      rif.req_valid = 2'b01;
      rif.req_byte0 = 8'hAB;
      push_exp(1'b0, 16'hABCD);
      settle();
      chk("idle_ready", rif.req_ready, 2'b00);
      cyc(); settle();
      chk("high_ready", rif.req_ready, 2'b01);
      chk("high_loadh", loadh, 1);
      chk("high_inh", inh, 8'hAB);
      chk("high_loadl", loadl, 0);
      chk("high_word_valid", word_valid, 0);
      cyc();
      rif.req_byte0 = 8'hCD;
      settle();
      chk("low_loadl", loadl, 1);
      chk("low_inl", inl, 8'hCD);
      chk("low_loadh", loadh, 0);
      chk("low_reg_hi", reg_q[N-1:H], 8'hAB);
      chk("low_word_valid", word_valid, 0);
      cyc();
      rif.req_valid = 2'b00;
      settle();
      chk("done_word_valid", word_valid, 1);
      check_word();
      chk("done_inh", inh, 0);
      chk("done_inl", inl, 0);
      cyc(); settle();
      chk("after_done_word_valid", word_valid, 0);
      chk("count_one", word_count, CNT_W'(exp_count));

      // Both requesters valid straight out of reset.
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      exp_count = 0;
      cyc();
      push_exp(1'b0, {hi_b(0, 0), lo_b(0, 0)});
      push_exp(1'b1, {hi_b(1, 0), lo_b(1, 0)});
      push_exp(1'b0, {hi_b(0, 1), lo_b(0, 1)});
      push_exp(1'b1, {hi_b(1, 1), lo_b(1, 1)});
      rr_run(2, 2, 40);
      settle();
      chk("rr_count_four", word_count, 4);

      // Requester 1 stalls three cycles between beats while requester 0 waits.
      rif.req_valid = 2'b10;
      rif.req_byte1 = 8'h3C;
      push_exp(1'b1, 16'h3C5A);
      settle();
      cyc(); settle();
      chk("stall_high_ready", rif.req_ready, 2'b10);
      chk("stall_high_loadh", loadh, 1);
      chk("stall_high_inh", inh, 8'h3C);
      for (int s = 0; s < 3; s++) begin
         cyc();
         rif.req_valid = 2'b01;
         rif.req_byte0 = 8'hEE;
         settle();
         chk("stall_ready", rif.req_ready, 2'b10);
         chk("stall_loadh", loadh, 0);
         chk("stall_loadl", loadl, 0);
         chk("stall_reg_hi", reg_q[N-1:H], 8'h3C);
         chk("stall_word_valid", word_valid, 0);
      end
      cyc();
      rif.req_valid = 2'b11;
      rif.req_byte1 = 8'h5A;
      settle();
      chk("stall_loadl_beat", loadl, 1);
      chk("stall_inl", inl, 8'h5A);
      cyc();
      rif.req_valid = 2'b00;
      settle();
      chk("stall_word_valid_done", word_valid, 1);
      check_word();
      cyc(); settle();
      chk("stall_count", word_count, CNT_W'(exp_count));

      // Abort in IDLE, then abort in LOW after high beat 0x12.
      abort = 1'b1;
      settle();
      chk("idle_abort_clear", reg_clear, 1);
      chk("idle_abort_ready", rif.req_ready, 2'b00);
      cyc();
      abort = 1'b0;
      rif.req_valid = 2'b01;
      rif.req_byte0 = 8'h12;
      settle();
      chk("idle_abort_reg", reg_q, 0);
      cyc(); settle();
      chk("abort_high_loadh", loadh, 1);
      chk("abort_high_inh", inh, 8'h12);
      cyc();
      abort = 1'b1;
      rif.req_byte0 = 8'h34;
      settle();
      chk("abort_reg_hi", reg_q[N-1:H], 8'h12);
      chk("abort_reg_clear", reg_clear, 1);
      chk("abort_loadl", loadl, 0);
      chk("abort_ready", rif.req_ready, 2'b00);
      chk("abort_word_valid", word_valid, 0);
      cyc();
      abort = 1'b0;
      rif.req_valid = 2'b00;
      settle();
      chk("abort_reg_zero", reg_q, 0);
      chk("abort_count", word_count, CNT_W'(exp_count));
      chk("abort_idle_ready", rif.req_ready, 2'b00);
      chk("abort_no_word", word_valid, 0);
      cyc(); settle();
      chk("abort_no_word_later", word_valid, 0);
      push_exp(1'b0, {hi_b(0, 0), lo_b(0, 0)});
      push_exp(1'b1, {hi_b(1, 0), lo_b(1, 0)});
      rr_run(1, 1, 40);

      // Fill up to 256 words so the counter wraps to zero.
      nwrap = 256 - exp_count;
      for (int k = 0; k < nwrap; k++) push_exp(1'b0, {hi_b(0, k), lo_b(0, k)});
      rr_run(nwrap, 0, nwrap * 5 + 20);
      settle();
      chk("wrap_count", word_count, CNT_W'(exp_count));
      chk("wrap_total", exp_count, 256);

      // One more word, then reset in the middle of the next HIGH phase.
      push_exp(1'b1, {hi_b(1, 0), lo_b(1, 0)});
      rr_run(0, 1, 20);
      rif.req_valid = 2'b10;
      rif.req_byte1 = 8'h77;
      settle();
      cyc(); settle();
      chk("pre_reset_loadh", loadh, 1);
      chk("pre_reset_count", word_count, 1);
      reset = 1'b1;
      settle();
      cyc(); settle();
      chk("mid_rst_word_valid", word_valid, 0);
      chk("mid_rst_loadh", loadh, 0);
      chk("mid_rst_loadl", loadl, 0);
      chk("mid_rst_ready", rif.req_ready, 2'b00);
      chk("mid_rst_reg_clear", reg_clear, 1);
      chk("mid_rst_count", word_count, 0);
      chk("mid_rst_word_src", word_src, 0);
      chk("mid_rst_inh", inh, 0);
      chk("mid_rst_reg", reg_q, 0);
      reset = 1'b0;
      rif.req_valid = 2'b00;
      exp_count = 0;
      for (int s = 0; s < 6; s++) begin
         cyc(); settle();
         chk("post_rst_no_word", word_valid, 0);
      end
      chk("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
